// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down Gray counter with parallel load, wrap or saturate, and over/underflow pulses
module gray_updown_counter #(
  parameter int WIDTH = 3,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] cnt_nxt;
  logic ovf_nxt, unf_nxt;
  // Gray is derived from cnt_nxt so Output and Binary update on the same edge
  always_comb begin
    ovf_nxt = !Load && En && Up && (Binary == MAX);
    unf_nxt = !Load && En && !Up && (Binary == '0);
    cnt_nxt = Load ? LoadVal :
              !En ? Binary :
              (SATURATE != 0 && (ovf_nxt || unf_nxt)) ? Binary :
              Up ? Binary + WIDTH'(1) : Binary - WIDTH'(1);
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      Binary    <= '0;
      Output    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Binary    <= cnt_nxt;
      Output    <= cnt_nxt ^ (cnt_nxt >> 1);
      Overflow  <= ovf_nxt;
      Underflow <= unf_nxt;
    end
endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: directed vectors on 3-bit wrap, 3-bit saturate and 4-bit wrap instances
module tb_gray_updown_counter;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic En = 1'b0, Up = 1'b0, Load = 1'b0;
  logic [3:0] LoadVal = '0;
  logic [2:0] a_out, a_bin, b_out, b_bin;
  logic [3:0] c_out, c_bin;
  logic a_ovf, a_unf, b_ovf, b_unf, c_ovf, c_unf;
  int vectors = 0, errors = 0;

  always #5 Clk = ~Clk;

  gray_updown_counter #(.WIDTH(3), .SATURATE(0)) dut_a (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[2:0]),
    .Output(a_out), .Binary(a_bin), .Overflow(a_ovf), .Underflow(a_unf));
  gray_updown_counter #(.WIDTH(3), .SATURATE(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[2:0]),
    .Output(b_out), .Binary(b_bin), .Overflow(b_ovf), .Underflow(b_unf));
  gray_updown_counter #(.WIDTH(4), .SATURATE(0)) dut_c (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal),
    .Output(c_out), .Binary(c_bin), .Overflow(c_ovf), .Underflow(c_unf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    En = 0; Up = 0; Load = 0; LoadVal = '0;
    Reset = 0;
    #2;
    Reset = 1;
  endtask

  task automatic drive(input logic en, input logic up, input logic ld, input logic [3:0] lv);
    En = en; Up = up; Load = ld; LoadVal = lv;
    tick();
  endtask

  logic [2:0] gray3 [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] sat_bin [3] = '{3'd7, 3'd7, 3'd7};
  logic       sat_ovf [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    logic [3:0] m, prev_out, prev_m;
    logic en, up;
    #3;
    check("rst_out", a_out, 0);
    check("rst_bin", a_bin, 0);
    check("rst_flags", {a_ovf, a_unf}, 0);
    Reset = 1;
    // 3-bit wrap, counting up through the whole cycle
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0);
      check($sformatf("up_gray%0d", i), a_out, gray3[i]);
      check($sformatf("up_ovf%0d", i), a_ovf, i == 7);
    end
    do_reset();
    drive(1, 0, 0, 0);
    check("dn0_out", a_out, 3'b100);
    check("dn0_bin", a_bin, 7);
    check("dn0_unf", a_unf, 1);
    check("dn0_ovf", a_ovf, 0);
    drive(1, 0, 0, 0);
    check("dn1_out", a_out, 3'b101);
    check("dn1_bin", a_bin, 6);
    check("dn1_unf", a_unf, 0);
    // 3-bit saturate: load 6 then push past MAX
    do_reset();
    drive(0, 0, 1, 6);
    check("sat_ld_bin", b_bin, 6);
    check("sat_ld_out", b_out, 3'b101);
    check("sat_ld_ovf", b_ovf, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      check($sformatf("sat_bin%0d", i), b_bin, sat_bin[i]);
      check($sformatf("sat_out%0d", i), b_out, 3'b100);
      check($sformatf("sat_ovf%0d", i), b_ovf, sat_ovf[i]);
    end
    drive(1, 1, 1, 7);
    check("sat_reld_bin", b_bin, 7);
    check("sat_reld_ovf", b_ovf, 0);
    do_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check("sat_unf_bin", b_bin, 0);
    check("sat_unf_flag", b_unf, 1);
    check("sat_unf_out", b_out, 0);
    // 4-bit: load beats enable, then step and reverse
    do_reset();
    drive(1, 1, 1, 5);
    check("ld_en_bin", c_bin, 5);
    check("ld_en_out", c_out, 4'b0111);
    check("ld_en_ovf", c_ovf, 0);
    drive(1, 1, 0, 0);
    check("ld_step_bin", c_bin, 6);
    check("ld_step_out", c_out, 4'b0101);
    drive(1, 0, 0, 0);
    check("rev_dn_out", c_out, 4'b0111);
    drive(1, 1, 0, 0);
    check("rev_up_out", c_out, 4'b0101);
    drive(1, 1, 1, 15);
    drive(1, 1, 1, 15);
    check("ld_max_ovf", c_ovf, 0);
    // random walk on the 4-bit instance against a binary model
    do_reset();
    m = 0;
    for (int i = 0; i < 1000; i++) begin
      en = 1'($urandom_range(0, 1));
      up = 1'($urandom_range(0, 1));
      prev_out = c_out;
      prev_m = m;
      if (en) m = up ? m + 4'd1 : m - 4'd1;
      drive(en, up, 0, 0);
      check("rnd_bin", c_bin, m);
      check("rnd_gray", c_out, m ^ (m >> 1));
      check("rnd_ham", $countones(prev_out ^ c_out), en ? 1 : 0);
      check("rnd_flags", {c_ovf, c_unf}, {en && up && prev_m == 15, en && !up && prev_m == 0});
    end
    // asynchronous reset mid-count
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0);
    check("pre_arst_bin", a_bin, 5);
    Load = 1; LoadVal = 4'd3;
    #2;
    Reset = 0;
    #1;
    check("arst_bin", a_bin, 0);
    check("arst_out", a_out, 0);
    check("arst_flags", {a_ovf, a_unf}, 0);
    Load = 0;
    #1;
    Reset = 1;
    drive(1, 1, 0, 0);
    check("post_arst_out", a_out, 3'b001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
